// File: rtl/control_multi_param.sv
// Multicycle RISC-V control FSM with configurable memory latency.
// Decodes the IR opcode into the multicycle datapath mux selects and write enables.
// Parameters:
//   MEM_WAIT        : extra cycles per memory state in fixed-latency mode (0..15)
//   HANDSHAKE       : 1 = memory states hold until iMemReady, 0 = use the wait counter
//   HALT_ON_ILLEGAL : 1 = TRAP holds until reset, 0 = TRAP returns to FETCH
// Ports:
//   iCLK, iRST      : clock, synchronous active-high reset
//   iOpcode         : IR[6:0]
//   iMemReady       : memory completion (HANDSHAKE=1 only)
//   oEscreveIR/PC/PCCond/PCBack : IR, PC, branch-PC and PCBack write enables
//   oOrigAULA/oOrigBULA/oMem2Reg/oALUOp : 2-bit selects and ALU op class
//   oOrigPC, oIouD, oRegWrite, oMemWrite, oMemRead : PC/addr source, strobes
//   oIllegal        : high while in TRAP
//   oInstrDone      : pulse in the last cycle of each completed instruction
//   oState          : current state code
module control_multi_param #(
    parameter int unsigned MEM_WAIT        = 1,
    parameter int unsigned HANDSHAKE       = 0,
    parameter int unsigned HALT_ON_ILLEGAL = 0
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [6:0] iOpcode,
    input  logic       iMemReady,
    output logic       oEscreveIR,
    output logic       oEscrevePC,
    output logic       oEscrevePCCond,
    output logic       oEscrevePCBack,
    output logic [1:0] oOrigAULA,
    output logic [1:0] oOrigBULA,
    output logic [1:0] oMem2Reg,
    output logic [1:0] oALUOp,
    output logic       oOrigPC,
    output logic       oIouD,
    output logic       oRegWrite,
    output logic       oMemWrite,
    output logic       oMemRead,
    output logic       oIllegal,
    output logic       oInstrDone,
    output logic [3:0] oState
);

    localparam int unsigned W_ST  = 4;
    localparam int unsigned W_CNT = 4;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_LWSW   = 4'd2;
    localparam logic [3:0] ST_LW     = 4'd3;
    localparam logic [3:0] ST_LW_WB  = 4'd4;
    localparam logic [3:0] ST_SW     = 4'd5;
    localparam logic [3:0] ST_RTYPE  = 4'd6;
    localparam logic [3:0] ST_ALU_WB = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JAL    = 4'd9;
    localparam logic [3:0] ST_ADDI   = 4'd10;
    localparam logic [3:0] ST_JALR   = 4'd11;
    localparam logic [3:0] ST_LUI    = 4'd12;
    localparam logic [3:0] ST_AUIPC  = 4'd13;
    localparam logic [3:0] ST_TRAP   = 4'd14;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [W_ST-1:0]  r_state;
    logic [W_ST-1:0]  w_next_state;
    logic [W_CNT-1:0] r_cnt;
    logic [W_CNT-1:0] w_next_cnt;
    logic             w_last;
    logic             w_mem_state;

    // Completion of the current memory access
    assign w_last = (HANDSHAKE != 0) ? iMemReady : (r_cnt == W_CNT'(MEM_WAIT));

    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_LW) || (r_state == ST_SW);

    // Wait counter runs only while a fixed-latency access is still in progress
    assign w_next_cnt = ((HANDSHAKE == 0) && w_mem_state && !w_last)
                        ? r_cnt + W_CNT'(1) : '0;

    assign oState = r_state;

    // State and wait-counter registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next_state   = r_state;
        oEscreveIR     = 1'b0;
        oEscrevePC     = 1'b0;
        oEscrevePCCond = 1'b0;
        oEscrevePCBack = 1'b0;
        oOrigAULA      = 2'b00;
        oOrigBULA      = 2'b00;
        oMem2Reg       = 2'b00;
        oALUOp         = 2'b00;
        oOrigPC        = 1'b0;
        oIouD          = 1'b0;
        oRegWrite      = 1'b0;
        oMemWrite      = 1'b0;
        oMemRead       = 1'b0;
        oIllegal       = 1'b0;
        oInstrDone     = 1'b0;

        case (r_state)
            ST_FETCH: begin
                oMemRead  = 1'b1;
                oOrigAULA = 2'b10;
                oOrigBULA = 2'b01;
                // IR/PC written once, in the final fetch cycle only
                if (w_last) begin
                    oEscreveIR     = 1'b1;
                    oEscrevePC     = 1'b1;
                    oEscrevePCBack = 1'b1;
                    w_next_state   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                oOrigBULA = 2'b10;
                case (iOpcode)
                    OPC_LOAD, OPC_STORE: w_next_state = ST_LWSW;
                    OPC_RTYPE:           w_next_state = ST_RTYPE;
                    OPC_BRANCH:          w_next_state = ST_BRANCH;
                    OPC_JAL:             w_next_state = ST_JAL;
                    OPC_OPIMM:           w_next_state = ST_ADDI;
                    OPC_JALR:            w_next_state = ST_JALR;
                    OPC_LUI:             w_next_state = ST_LUI;
                    OPC_AUIPC:           w_next_state = ST_AUIPC;
                    default:             w_next_state = ST_TRAP;
                endcase
            end
            ST_LWSW: begin
                oOrigAULA = 2'b01;
                oOrigBULA = 2'b10;
                case (iOpcode)
                    OPC_LOAD:  w_next_state = ST_LW;
                    OPC_STORE: w_next_state = ST_SW;
                    default:   w_next_state = ST_TRAP;
                endcase
            end
            ST_LW: begin
                oIouD    = 1'b1;
                oMemRead = 1'b1;
                if (w_last) w_next_state = ST_LW_WB;
            end
            ST_LW_WB: begin
                oMem2Reg     = 2'b10;
                oRegWrite    = 1'b1;
                oInstrDone   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_SW: begin
                oIouD     = 1'b1;
                oMemWrite = 1'b1;
                if (w_last) begin
                    oInstrDone   = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_RTYPE: begin
                oOrigAULA    = 2'b01;
                oALUOp       = 2'b10;
                w_next_state = ST_ALU_WB;
            end
            ST_ADDI: begin
                oOrigAULA    = 2'b01;
                oOrigBULA    = 2'b10;
                oALUOp       = 2'b10;
                w_next_state = ST_ALU_WB;
            end
            ST_LUI: begin
                oOrigBULA    = 2'b10;
                oALUOp       = 2'b11;
                w_next_state = ST_ALU_WB;
            end
            ST_AUIPC: begin
                // A operand is PCBack (select 00), the PC of this instruction
                oOrigBULA    = 2'b10;
                w_next_state = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                oRegWrite    = 1'b1;
                oInstrDone   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                oEscrevePCCond = 1'b1;
                oOrigAULA      = 2'b01;
                oOrigPC        = 1'b1;
                oALUOp         = 2'b01;
                oInstrDone     = 1'b1;
                w_next_state   = ST_FETCH;
            end
            ST_JAL: begin
                oEscrevePC   = 1'b1;
                oMem2Reg     = 2'b01;
                oOrigPC      = 1'b1;
                oRegWrite    = 1'b1;
                oInstrDone   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_JALR: begin
                oEscrevePC   = 1'b1;
                oOrigAULA    = 2'b01;
                oOrigBULA    = 2'b10;
                oMem2Reg     = 2'b01;
                oRegWrite    = 1'b1;
                oInstrDone   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_TRAP: begin
                // PC already advanced in FETCH, so leaving TRAP skips the instruction
                oIllegal     = 1'b1;
                w_next_state = (HALT_ON_ILLEGAL != 0) ? ST_TRAP : ST_FETCH;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

endmodule
